// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_pkg (package)
// Description : Shared constants for the synchronous flagged FIFO: default
//               data and address widths, and the DEPTH derivation from the
//               address width.
// Contents    : DEF_WIDTH, DEF_ADD_WIDTH, depth_of()
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_pkg;

  localparam int DEF_WIDTH     = 8;
  localparam int DEF_ADD_WIDTH = 4;

  // Number of words addressable by an address of width aw.
  function automatic int depth_of(input int aw);
    return 1 << aw;
  endfunction

endpackage : fifo_pkg
`default_nettype wire

// File: rtl/fifo_sync_mem.sv
`default_nettype none
// ============================================================================
// Module      : fifo_sync_mem
// Description : Word storage for fifo_sync_flags. The array is written
//               synchronously and is read through a registered port, so
//               the read data appears one clock after the read request.
//               The array itself is not reset. Only the read register is.
// Ports       : clk      - clock, rising edge
//               rstN     - asynchronous active-low reset (read register only)
//               we_i     - write enable
//               waddr_i  - write address
//               wdata_i  - write data
//               re_i     - read enable; rdata_o holds when low
//               raddr_i  - read address
//               rdata_o  - registered read data
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_sync_mem
  import fifo_pkg::*;
#(
  parameter int width     = DEF_WIDTH,
  parameter int add_width = DEF_ADD_WIDTH
) (
  input  logic                 clk,
  input  logic                 rstN,
  input  logic                 we_i,
  input  logic [add_width-1:0] waddr_i,
  input  logic [width-1:0]     wdata_i,
  input  logic                 re_i,
  input  logic [add_width-1:0] raddr_i,
  output logic [width-1:0]     rdata_o
);

  localparam int DEPTH = depth_of(add_width);

  logic [width-1:0] mem_q [DEPTH];
  logic [width-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule : fifo_sync_mem
`default_nettype wire

// File: rtl/fifo_sync_flags.sv
`default_nettype none
// ============================================================================
// Module      : fifo_sync_flags
// Description : Single-clock FIFO with registered read data and active-low
//               full, empty, almost-full and almost-empty flags, plus an
//               occupancy count. Pointers carry an extra wrap bit, so full
//               and empty are decoded from the pointers alone.
// Ports       : clk           - clock, rising edge
//               rstN          - asynchronous active-low reset
//               clr           - synchronous flush (priority over W_EN/R_EN)
//               f_in          - write data
//               W_EN / R_EN   - write / read requests
//               f_out         - read data, one clock after an accepted read
//               fullN         - low when count == DEPTH
//               emptyN        - low when count == 0
//               almost_fullN  - low when count >= af_level
//               almost_emptyN - low when count <= ae_level
//               count         - occupancy 0..DEPTH
//               ovf_err       - sticky: write rejected at full (FIFO_ERR_EN)
//               unf_err       - sticky: read rejected at empty (FIFO_ERR_EN)
// Config      : define FIFO_ERR_EN to add the ovf_err/unf_err outputs
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_sync_flags
  import fifo_pkg::*;
#(
  parameter int width     = DEF_WIDTH,
  parameter int add_width = DEF_ADD_WIDTH,
  parameter int af_level  = depth_of(add_width) - 2,
  parameter int ae_level  = 2
) (
  input  logic                 clk,
  input  logic                 rstN,
  input  logic                 clr,
  input  logic [width-1:0]     f_in,
  input  logic                 W_EN,
  input  logic                 R_EN,
  output logic [width-1:0]     f_out,
  output logic                 fullN,
  output logic                 emptyN,
  output logic                 almost_fullN,
  output logic                 almost_emptyN,
  output logic [add_width:0]   count
`ifdef FIFO_ERR_EN
  ,
  output logic                 ovf_err,
  output logic                 unf_err
`endif
);

  localparam logic [add_width:0] C_ONE = (add_width+1)'(1);
  localparam logic [add_width:0] C_AF  = (add_width+1)'(af_level);
  localparam logic [add_width:0] C_AE  = (add_width+1)'(ae_level);

  logic [add_width:0] wr_ptr_q, wr_ptr_d;
  logic [add_width:0] rd_ptr_q, rd_ptr_d;
  logic [add_width:0] count_q,  count_d;
  logic               wr_acc, rd_acc;
  logic               full, empty;

  // Full: same slot, opposite lap. Empty: identical pointers.
  assign full  = (wr_ptr_q[add_width] != rd_ptr_q[add_width]) &&
                 (wr_ptr_q[add_width-1:0] == rd_ptr_q[add_width-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);

  assign wr_acc = W_EN && !full;
  assign rd_acc = R_EN && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + C_ONE;
      if (rd_acc) rd_ptr_d = rd_ptr_q + C_ONE;
      case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + C_ONE;
        2'b01:   count_d = count_q - C_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // A flush must leave memory and f_out untouched, so it gates both ports.
  fifo_sync_mem #(
    .width     (width),
    .add_width (add_width)
  ) u_mem (
    .clk     (clk),
    .rstN    (rstN),
    .we_i    (wr_acc && !clr),
    .waddr_i (wr_ptr_q[add_width-1:0]),
    .wdata_i (f_in),
    .re_i    (rd_acc && !clr),
    .raddr_i (rd_ptr_q[add_width-1:0]),
    .rdata_o (f_out)
  );

  assign fullN         = !full;
  assign emptyN        = !empty;
  assign almost_fullN  = !(count_q >= C_AF);
  assign almost_emptyN = !(count_q <= C_AE);
  assign count         = count_q;

`ifdef FIFO_ERR_EN
  logic ovf_q, unf_q;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else if (clr) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (W_EN && full)  ovf_q <= 1'b1;
      if (R_EN && empty) unf_q <= 1'b1;
    end
  end

  assign ovf_err = ovf_q;
  assign unf_err = unf_q;
`endif

endmodule : fifo_sync_flags
`default_nettype wire

// File: tb/tb_fifo_sync_flags.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_sync_flags
// Description : Self-checking bench for fifo_sync_flags (DEPTH=4, af=3,
//               ae=1). A queue-based reference model supplies the expected
//               outputs. A directed table adds hand-written count/f_out
//               expectations, followed by an asynchronous reset pulse and
//               randomized traffic. Define FIFO_ERR_EN to also check the
//               sticky error outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_sync_flags;

  logic       clk = 1'b0;
  logic       rstN = 1'b0;
  logic       clr = 1'b0;
  logic       W_EN = 1'b0;
  logic       R_EN = 1'b0;
  logic [7:0] f_in = 8'h00;
  logic [7:0] f_out;
  logic       fullN, emptyN, almost_fullN, almost_emptyN;
  logic [2:0] count;
`ifdef FIFO_ERR_EN
  logic       ovf_err, unf_err;
`endif

  fifo_sync_flags #(
    .width     (8),
    .add_width (2),
    .af_level  (3),
    .ae_level  (1)
  ) dut (
    .clk           (clk),
    .rstN          (rstN),
    .clr           (clr),
    .f_in          (f_in),
    .W_EN          (W_EN),
    .R_EN          (R_EN),
    .f_out         (f_out),
    .fullN         (fullN),
    .emptyN        (emptyN),
    .almost_fullN  (almost_fullN),
    .almost_emptyN (almost_emptyN),
    .count         (count)
`ifdef FIFO_ERR_EN
    ,
    .ovf_err       (ovf_err),
    .unf_err       (unf_err)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: the FIFO contents as a queue, plus the last word read.
  logic [7:0] mq[$];
  logic [7:0] mf = 8'h00;
  bit         m_ovf = 1'b0;
  bit         m_unf = 1'b0;

  typedef struct {
    bit         w;
    bit         r;
    bit         c;
    logic [7:0] d;
    int         cnt;
    logic [7:0] fo;
  } vec_t;

  vec_t tbl[$];

  task automatic cmp(input string nm, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int n;
    n = mq.size();
    cmp({tag, "_count"},  int'(count),         n);
    cmp({tag, "_fout"},   int'(f_out),         int'(mf));
    cmp({tag, "_fullN"},  int'(fullN),         (n == 4) ? 0 : 1);
    cmp({tag, "_emptyN"}, int'(emptyN),        (n == 0) ? 0 : 1);
    cmp({tag, "_afN"},    int'(almost_fullN),  (n >= 3) ? 0 : 1);
    cmp({tag, "_aeN"},    int'(almost_emptyN), (n <= 1) ? 0 : 1);
`ifdef FIFO_ERR_EN
    cmp({tag, "_ovf"},    int'(ovf_err),       int'(m_ovf));
    cmp({tag, "_unf"},    int'(unf_err),       int'(m_unf));
`endif
  endtask

  task automatic model_step(input bit w, input bit r, input bit c, input logic [7:0] d);
    bit full_m;
    bit empty_m;
    full_m  = (mq.size() == 4);
    empty_m = (mq.size() == 0);
    if (c) begin
      mq.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      if (w && full_m)  m_ovf = 1'b1;
      if (r && empty_m) m_unf = 1'b1;
      if (r && !empty_m) mf = mq.pop_front();
      if (w && !full_m)  mq.push_back(d);
    end
  endtask

  // Entered and left at a falling edge: drive, clock, then check.
  task automatic apply(input bit w, input bit r, input bit c, input logic [7:0] d,
                       input string tag);
    W_EN = w;
    R_EN = r;
    clr  = c;
    f_in = d;
    @(posedge clk);
    model_step(w, r, c, d);
    @(negedge clk);
    check_all(tag);
  endtask

  function automatic void addv(input bit w, input bit r, input bit c,
                               input logic [7:0] d, input int cnt, input logic [7:0] fo);
    vec_t v;
    v.w = w; v.r = r; v.c = c; v.d = d; v.cnt = cnt; v.fo = fo;
    tbl.push_back(v);
  endfunction

  initial begin
    // Idle after reset
    addv(0, 0, 0, 8'h00, 0, 8'h00);
    // Fill to full, then one rejected write
    addv(1, 0, 0, 8'h11, 1, 8'h00);
    addv(1, 0, 0, 8'h22, 2, 8'h00);
    addv(1, 0, 0, 8'h33, 3, 8'h00);
    addv(1, 0, 0, 8'h44, 4, 8'h00);
    addv(1, 0, 0, 8'h55, 4, 8'h00);
    // Drain, then a read at empty holds f_out
    addv(0, 1, 0, 8'h00, 3, 8'h11);
    addv(0, 1, 0, 8'h00, 2, 8'h22);
    addv(0, 1, 0, 8'h00, 1, 8'h33);
    addv(0, 1, 0, 8'h00, 0, 8'h44);
    addv(0, 1, 0, 8'h00, 0, 8'h44);
    // Wrap: 2-deep backlog, then simultaneous write/read across the wrap
    addv(1, 0, 0, 8'hA0, 1, 8'h44);
    addv(1, 0, 0, 8'hA1, 2, 8'h44);
    addv(1, 1, 0, 8'hA2, 2, 8'hA0);
    addv(1, 1, 0, 8'hA3, 2, 8'hA1);
    addv(1, 1, 0, 8'hA4, 2, 8'hA2);
    addv(1, 1, 0, 8'hA5, 2, 8'hA3);
    addv(0, 1, 0, 8'h00, 1, 8'hA4);
    addv(0, 1, 0, 8'h00, 0, 8'hA5);
    // Full with both requests: read only
    addv(1, 0, 0, 8'hB0, 1, 8'hA5);
    addv(1, 0, 0, 8'hB1, 2, 8'hA5);
    addv(1, 0, 0, 8'hB2, 3, 8'hA5);
    addv(1, 0, 0, 8'hB3, 4, 8'hA5);
    addv(1, 1, 0, 8'hB4, 3, 8'hB0);
    addv(0, 1, 0, 8'h00, 2, 8'hB1);
    addv(0, 1, 0, 8'h00, 1, 8'hB2);
    addv(0, 1, 0, 8'h00, 0, 8'hB3);
    // Empty with both requests: write only, f_out holds
    addv(1, 1, 0, 8'hC0, 1, 8'hB3);
    // Flush at count 3 beats a concurrent write and read
    addv(1, 0, 0, 8'hC1, 2, 8'hB3);
    addv(1, 0, 0, 8'hC2, 3, 8'hB3);
    addv(1, 1, 1, 8'hC3, 0, 8'hB3);
    addv(0, 0, 0, 8'h00, 0, 8'hB3);
    // Restart from pointer zero after the flush
    addv(1, 0, 0, 8'hD0, 1, 8'hB3);
    addv(0, 1, 0, 8'h00, 0, 8'hD0);

    // Reset held low across edges
    rstN = 1'b0;
    repeat (2) @(negedge clk);
    check_all("reset");
    rstN = 1'b1;

    foreach (tbl[i]) begin
      apply(tbl[i].w, tbl[i].r, tbl[i].c, tbl[i].d, $sformatf("vec%0d", i));
      cmp($sformatf("vec%0d_tbl_count", i), int'(count), tbl[i].cnt);
      cmp($sformatf("vec%0d_tbl_fout", i),  int'(f_out), int'(tbl[i].fo));
    end

    // Asynchronous reset pulse between clock edges
    apply(1, 0, 0, 8'hE0, "pre_rst0");
    apply(1, 0, 0, 8'hE1, "pre_rst1");
    apply(1, 0, 0, 8'hE2, "pre_rst2");
    W_EN = 1'b0;
    #1 rstN = 1'b0;
    #1;
    cmp("async_count",  int'(count),         0);
    cmp("async_emptyN", int'(emptyN),        0);
    cmp("async_fullN",  int'(fullN),         1);
    cmp("async_aeN",    int'(almost_emptyN), 0);
    cmp("async_afN",    int'(almost_fullN),  1);
    cmp("async_fout",   int'(f_out),         0);
    #1 rstN = 1'b1;
    mq.delete();
    mf    = 8'h00;
    m_ovf = 1'b0;
    m_unf = 1'b0;
    @(negedge clk);
    check_all("post_rst");

`ifdef FIFO_ERR_EN
    // Overflow flag is sticky until a flush
    for (int i = 0; i < 4; i++) apply(1, 0, 0, 8'hF0 + 8'(i), "err_fill");
    apply(1, 0, 0, 8'hFF, "err_ovf");
    cmp("ovf_set", int'(ovf_err), 1);
    apply(0, 0, 0, 8'h00, "err_hold");
    cmp("ovf_hold", int'(ovf_err), 1);
    apply(0, 0, 1, 8'h00, "err_clr");
    cmp("ovf_clr", int'(ovf_err), 0);
    apply(0, 1, 0, 8'h00, "err_unf");
    cmp("unf_set", int'(unf_err), 1);
    apply(0, 0, 1, 8'h00, "err_clr2");
`endif

    // Randomized traffic, write-biased then read-biased, occasional flush
    for (int i = 0; i < 400; i++) begin
      bit w, r, c;
      if (i < 200) begin
        w = ($urandom_range(0, 3) != 0);
        r = ($urandom_range(0, 3) == 0);
      end else begin
        w = ($urandom_range(0, 3) == 0);
        r = ($urandom_range(0, 3) != 0);
      end
      c = ($urandom_range(0, 39) == 0);
      apply(w, r, c, 8'($urandom), $sformatf("rnd%0d", i));
    end

    W_EN = 1'b0;
    R_EN = 1'b0;
    clr  = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_fifo_sync_flags
`default_nettype wire

// File: doc/fifo_sync_flags.md
FIFO_SYNC_FLAGS -- requirements
Module: fifo_sync_flags

Interface
REQ-001 Parameters SHALL be as follows, one per line:
- width, 8, data bits per word
- add_width, 4, address bits; depth DEPTH = 2**add_width
- af_level, DEPTH-2, almost-full threshold in words
- ae_level, 2, almost-empty threshold in words
REQ-002 Ports SHALL be as follows, one per line:
- clk  in  1  single clock; all state changes on its rising edge
- rstN  in  1  reset, asynchronous, active-low
- clr  in  1  synchronous flush, active-high
- f_in  in  width  write data
- W_EN  in  1  write request
- R_EN  in  1  read request
- f_out  out  width  read data, registered
- fullN  out  1  low when count == DEPTH
- emptyN  out  1  low when count == 0
- almost_fullN  out  1  low when count >= af_level
- almost_emptyN  out  1  low when count <= ae_level
- count  out  add_width+1  current occupancy, 0..DEPTH
REQ-003 The block SHALL have exactly one clock, clk, and its reset SHALL be asynchronous and active-low, named rstN.

Function
REQ-004 A write SHALL be accepted when W_EN && fullN; a read SHALL be accepted when R_EN && emptyN; a rejected request SHALL change no state.
REQ-005 Write and read pointers SHALL be add_width+1 bits; the low add_width bits SHALL address memory; the MSB SHALL be a wrap bit toggling on wrap from DEPTH-1 to 0.
REQ-006 full SHALL mean wrap bits differ with equal low bits; empty SHALL mean all pointer bits are equal; both SHALL agree with count.
REQ-007 On an accepted read, f_out SHALL present the word at the read pointer after exactly one clk edge (latency 1); otherwise f_out SHALL hold.
REQ-008 count SHALL increment on write-only, decrement on read-only, and hold on simultaneous write+read or on no access.
REQ-009 When full with W_EN && R_EN, only the read SHALL be accepted; count SHALL become DEPTH-1.
REQ-010 When empty with W_EN && R_EN, only the write SHALL be accepted; count SHALL become 1, and f_out SHALL hold.
REQ-011 All flags SHALL derive combinationally from registered count/pointers and SHALL update in the same cycle count changes.
REQ-012 clr SHALL take priority over W_EN/R_EN: pointers and count SHALL go to 0 on that edge; memory contents and f_out SHALL hold.

Reset
REQ-013 While rstN is low: pointers=0, count=0, f_out=0, fullN=1, emptyN=0, almost_fullN=1, almost_emptyN=0.
REQ-014 Reset asserted mid-operation SHALL discard all stored words immediately, without waiting for clk.
REQ-015 Memory array contents SHALL NOT require reset.

Configuration
REQ-016 Macro FIFO_ERR_EN, when defined, SHALL add outputs ovf_err and unf_err, both 1 bit. Each SHALL go high sticky on a write rejected due to full or a read rejected due to empty. Both SHALL be cleared by rstN or clr.
REQ-017 Without FIFO_ERR_EN, those ports and their logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-018 A shared package/include fifo_pkg SHALL hold the DEPTH derivation and the default width/add_width constants.
REQ-019 Storage SHALL be one sub-module fifo_sync_mem: a write-synchronous array with a registered read port.

Verification
All scenarios use width=8, add_width=2 (DEPTH=4), af_level=3, ae_level=1.
REQ-020 Reset, then idle: count=0, emptyN=0, fullN=1, almost_emptyN=0, almost_fullN=1, f_out=0.
REQ-021 Write 0x11,0x22,0x33,0x44: count 1,2,3,4; almost_emptyN high after the 2nd write; almost_fullN low after the 3rd; fullN low after the 4th. A 5th write 0x55 is rejected and count stays 4.
REQ-022 From full, read 4 times: f_out is 0x11,0x22,0x33,0x44, each one cycle after its accepted read. emptyN is low after the last read; a further read leaves f_out=0x44.
REQ-023 Wrap: 6 write/read pairs, with a 2-deep backlog, reading back 0xA0..0xA5 in order across the pointer wrap; count stays constant during the simultaneous phase.
REQ-024 Full with W_EN=R_EN=1: count becomes 3 and the oldest word is output. Empty with W_EN=R_EN=1: count becomes 1 and f_out holds.
REQ-025 clr at count=3 gives count=0 and emptyN=0 next cycle. rstN pulsed low between edges gives an immediate flag reset. With FIFO_ERR_EN, a write at full sets ovf_err=1 until clr.
